pixeldriver_chain: RTL and testbench

Parametrised TLC5941 chain driver that replaces fixed-pattern LED driving with data fetched from an external bit-addressed frame store. It drives CHAINS parallel serial chains, each DRIVERS TLC5941 devices deep. It loads dot-correction at start-up and on request, then streams grayscale frames continuously. XLAT is issued only inside the BLANK window. It sits between the frame store and the LED board pins.

---
 rtl/pixeldriver_pkg.sv | 11 +
 rtl/tlc_clkgen.sv | 38 +++
 rtl/pixeldriver_chain.sv | 131 +++++++++++++
 tb/tb_pixeldriver_chain.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pixeldriver_pkg.sv
// Shared constants and FSM state type for the TLC5941 chain driver.
package pixeldriver_pkg;
   localparam int GS_BITS     = 12;
   localparam int DC_BITS     = 6;
   localparam int CH_PER_DEV  = 16;
   localparam int GS_PERIOD   = 4096;
   localparam int DC_DEV_BITS = CH_PER_DEV * DC_BITS;
   localparam int GS_DEV_BITS = CH_PER_DEV * GS_BITS;

   typedef enum logic [2:0] {RESET, DC_SHIFT, DC_LATCH, GS_SHIFT, GS_WAIT} state_t;
endpackage

// File: rtl/tlc_clkgen.sv
// Free-running divider shared by SCLK/GSCLK, grayscale period counter and BLANK.
module tlc_clkgen import pixeldriver_pkg::*; #(
   parameter int CLK_DIV = 4
) (
   input  logic                       clock,
   input  logic                       reset_n,
   output logic [$clog2(CLK_DIV)-1:0] div_cnt,
   output logic                       tick,
   output logic                       gsclk,
   output logic                       blank
);
   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] HALF = DW'(CLK_DIV / 2);

   logic [GS_BITS-1:0] gs_count;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         div_cnt  <= '0;
         gs_count <= '0;
         blank    <= 1'b1;
         gsclk    <= 1'b0;
      end else begin
         gsclk <= (div_cnt >= HALF);
         if (div_cnt == LAST) begin
            div_cnt  <= '0;
            gs_count <= gs_count + GS_BITS'(1);
            // blank tracks the count it is about to take
            blank    <= (gs_count == GS_BITS'(GS_PERIOD - 1));
         end else begin
            div_cnt <= div_cnt + DW'(1);
         end
      end
   end

   assign tick = (div_cnt == '0);
endmodule

// File: rtl/pixeldriver_chain.sv
// TLC5941 chain driver: DC load at start-up/on request, then continuous GS frames
// streamed from a bit-addressed frame store, latched only inside BLANK.
module pixeldriver_chain import pixeldriver_pkg::*; #(
   parameter int CHAINS  = 12,
   parameter int DRIVERS = 1,
   parameter int CLK_DIV = 4
) (
   input  logic                                 clock,
   input  logic                                 reset_n,
   input  logic                                 dc_reload,
   output logic                                 rd_en,
   output logic                                 rd_dc,
   output logic [$clog2(DRIVERS*GS_DEV_BITS)-1:0] rd_addr,
   input  logic [CHAINS-1:0]                    rd_data,
   output logic                                 led_sclk,
   output logic [CHAINS-1:0]                    led_sin,
   output logic                                 led_mode,
   output logic                                 led_blank,
   output logic                                 led_xlat,
   output logic                                 led_gsclk,
   output logic                                 busy,
   output logic                                 frame_done
);
   localparam int AW = $clog2(DRIVERS * GS_DEV_BITS);
   localparam int DW = $clog2(CLK_DIV);
   localparam logic [AW-1:0] DC_LAST = AW'(DRIVERS * DC_DEV_BITS - 1);
   localparam logic [AW-1:0] GS_LAST = AW'(DRIVERS * GS_DEV_BITS - 1);
   localparam logic [DW-1:0] HALF    = DW'(CLK_DIV / 2);
   localparam logic [DW-1:0] LOAD    = DW'(1);

   state_t        state;
   logic [DW-1:0] div_cnt;
   logic          tick;
   logic          active, cur_pad, pad, last_sent, reload;
   logic          shifting;

   tlc_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
      .clock   (clock),
      .reset_n (reset_n),
      .div_cnt (div_cnt),
      .tick    (tick),
      .gsclk   (led_gsclk),
      .blank   (led_blank)
   );

   assign shifting = (state == DC_SHIFT) || (state == GS_SHIFT);
   assign rd_en    = shifting && tick && !pad && !last_sent;
   assign rd_dc    = led_mode;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= RESET;
         rd_addr    <= '0;
         active     <= 1'b0;
         cur_pad    <= 1'b0;
         pad        <= 1'b0;
         last_sent  <= 1'b0;
         reload     <= 1'b0;
         busy       <= 1'b0;
         led_sclk   <= 1'b0;
         led_sin    <= '0;
         led_mode   <= 1'b1;
         led_xlat   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         led_xlat   <= 1'b0;
         frame_done <= 1'b0;
         // SCLK lags the divider by a clock so SIN gets a full clock of setup
         led_sclk   <= active && (div_cnt >= HALF);
         if (active && div_cnt == LOAD) led_sin <= cur_pad ? '0 : rd_data;
         if (!active && div_cnt == LOAD) busy <= 1'b0;
         if (dc_reload) reload <= 1'b1;

         case (state)
            RESET: begin
               state     <= DC_SHIFT;
               led_mode  <= 1'b1;
               rd_addr   <= '0;
               last_sent <= 1'b0;
               pad       <= 1'b0;
               reload    <= dc_reload;
            end
            DC_SHIFT, GS_SHIFT: if (tick) begin
               if (pad) begin
                  active  <= 1'b1;
                  busy    <= 1'b1;
                  cur_pad <= 1'b1;
                  pad     <= 1'b0;
               end else if (!last_sent) begin
                  active  <= 1'b1;
                  busy    <= 1'b1;
                  cur_pad <= 1'b0;
                  if (rd_addr == (led_mode ? DC_LAST : GS_LAST)) last_sent <= 1'b1;
                  else rd_addr <= rd_addr + AW'(1);
               end else begin
                  active <= 1'b0;
                  state  <= (state == DC_SHIFT) ? DC_LATCH : GS_WAIT;
               end
            end
            DC_LATCH: begin
               if (led_xlat) begin
                  led_mode  <= 1'b0;
                  state     <= GS_SHIFT;
                  pad       <= 1'b1;
                  rd_addr   <= '0;
                  last_sent <= 1'b0;
               end else if (tick && led_blank) begin
                  led_xlat <= 1'b1;
               end
            end
            GS_WAIT: begin
               if (led_xlat) begin
                  rd_addr   <= '0;
                  last_sent <= 1'b0;
                  if (reload) begin
                     state    <= DC_SHIFT;
                     led_mode <= 1'b1;
                     reload   <= dc_reload;
                  end else begin
                     state <= GS_SHIFT;
                  end
               end else if (tick && led_blank) begin
                  led_xlat   <= 1'b1;
                  frame_done <= 1'b1;
               end
            end
            default: state <= RESET;
         endcase
      end
   end
endmodule

// File: tb/tb_pixeldriver_chain.sv
// Directed sequence with random frame data and reload timing; expectations come
// from bit lists, address order and the 4096-period blank arithmetic.
module tb_pixeldriver_chain;
   localparam int CHAINS  = 2;
   localparam int DRIVERS = 1;
   localparam int CLK_DIV = 4;
   localparam int DC_LEN  = 96;
   localparam int GS_LEN  = 192;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic              dc_reload = 1'b0;
   logic              rd_en, rd_dc;
   logic [7:0]        rd_addr;
   logic [CHAINS-1:0] rd_data = '0;
   logic              led_sclk, led_mode, led_blank, led_xlat, led_gsclk, busy, frame_done;
   logic [CHAINS-1:0] led_sin;

   int checks = 0;
   int errors = 0;
   int n = 0;
   int fall_n = 0;
   logic prev_sclk = 1'b0;
   logic [CHAINS-1:0] prev_sin = '0;
   bit xlat_ok = 1'b0;
   logic [CHAINS-1:0] gs_mem [GS_LEN];

   always #5 clock = ~clock;

   pixeldriver_chain #(.CHAINS(CHAINS), .DRIVERS(DRIVERS), .CLK_DIV(CLK_DIV)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .dc_reload  (dc_reload),
      .rd_en      (rd_en),
      .rd_dc      (rd_dc),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .led_sclk   (led_sclk),
      .led_sin    (led_sin),
      .led_mode   (led_mode),
      .led_blank  (led_blank),
      .led_xlat   (led_xlat),
      .led_gsclk  (led_gsclk),
      .busy       (busy),
      .frame_done (frame_done)
   );

   // Frame store: DC plane is {addr[0], ~addr[0]}, GS plane a random table.
   always @(posedge clock) begin
      if (rd_en) begin
         if (rd_dc) rd_data <= {rd_addr[0], ~rd_addr[0]};
         else       rd_data <= gs_mem[int'(rd_addr)];
      end else begin
         rd_data <= CHAINS'($urandom);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, n);
      end
   endtask

   function automatic logic [CHAINS-1:0] exp_bit(input bit dc, input bit pad, input int k);
      int a;
      a = k - int'(pad);
      if (pad && k == 0) return '0;
      if (dc) return {a[0], ~a[0]};
      return gs_mem[a];
   endfunction

   task automatic step();
      prev_sclk = led_sclk;
      prev_sin  = led_sin;
      @(posedge clock);
      n++;
      @(negedge clock);
      chk("gsclk", 32'(led_gsclk), 32'(n > 0 && ((n - 1) % CLK_DIV) >= CLK_DIV / 2));
      chk("blank", 32'(led_blank), 32'(((n / CLK_DIV) % 4096) == 0));
      if (led_sclk) chk("sclk_only_when_busy", 32'(busy), 1);
      if (led_xlat) begin
         chk("xlat_expected", 32'(xlat_ok), 1);
         chk("xlat_in_blank", 32'(led_blank), 1);
         chk("xlat_sclk_low", 32'(led_sclk), 0);
      end
      if (frame_done) chk("frame_done_with_xlat", 32'(led_xlat), 1);
   endtask

   task automatic do_reset(input int cycles);
      reset_n = 1'b0;
      repeat (cycles) @(posedge clock);
      n = 0;
      @(negedge clock);
      chk("rst_sclk",  32'(led_sclk), 0);
      chk("rst_sin",   32'(led_sin), 0);
      chk("rst_mode",  32'(led_mode), 1);
      chk("rst_blank", 32'(led_blank), 1);
      chk("rst_xlat",  32'(led_xlat), 0);
      chk("rst_gsclk", 32'(led_gsclk), 0);
      chk("rst_rd_en", 32'(rd_en), 0);
      chk("rst_rd_dc", 32'(rd_dc), 1);
      chk("rst_addr",  32'(rd_addr), 0);
      chk("rst_busy",  32'(busy), 0);
      chk("rst_fdone", 32'(frame_done), 0);
      reset_n = 1'b1;
   endtask

   task automatic expect_shift(input bit dc, input int nbits, input bit pad, input int reload_at);
      int edges = 0;
      int reads = 0;
      int w = 0;
      int last_fall = -100;
      bit started = 1'b0;
      while (w < nbits * CLK_DIV + 64) begin
         step();
         w++;
         if (dc_reload) dc_reload = 1'b0;
         if (rd_en) begin
            chk("rd_dc", 32'(rd_dc), 32'(dc));
            chk("rd_addr", 32'(rd_addr), 32'(reads));
            reads++;
         end
         if (led_sclk && !prev_sclk) begin
            chk("sin_setup", 32'(led_sin), 32'(prev_sin));
            chk("sin_data", 32'(led_sin), 32'(exp_bit(dc, pad, edges)));
            chk("mode_in_shift", 32'(led_mode), 32'(dc));
            edges++;
            if (edges == reload_at) dc_reload = 1'b1;
         end
         if (!led_sclk && prev_sclk) last_fall = n;
         if (busy) started = 1'b1;
         else if (started) break;
      end
      chk("shift_completed", 32'(started && !busy), 1);
      chk("edge_count", 32'(edges), 32'(nbits));
      chk("read_count", 32'(reads), 32'(nbits - int'(pad)));
      chk("busy_fall_after_sclk", 32'(n - last_fall), 1);
      fall_n = n;
   endtask

   task automatic expect_latch(input bit gs, input bit next_dc);
      int w = 0;
      int p_exp;
      p_exp = ((fall_n / CLK_DIV) / 4096 + 1) * 4096;
      xlat_ok = 1'b1;
      while (!led_xlat && w < 4096 * CLK_DIV + 64) begin
         step();
         w++;
         if (!led_xlat) chk("idle_no_read", 32'(rd_en), 0);
      end
      chk("xlat_seen", 32'(led_xlat), 1);
      chk("xlat_period", 32'(n / CLK_DIV), 32'(p_exp));
      chk("frame_done", 32'(frame_done), 32'(gs));
      chk("mode_at_xlat", 32'(led_mode), 32'(!gs));
      xlat_ok = 1'b0;
      step();
      chk("xlat_width", 32'(led_xlat), 0);
      chk("mode_after_xlat", 32'(led_mode), 32'(next_dc));
   endtask

   task automatic reshuffle();
      for (int i = 0; i < GS_LEN; i++) gs_mem[i] = CHAINS'($urandom);
   endtask

   initial begin
      int pre;
      reshuffle();
      do_reset(3);
      // abandon a DC shift part-way through with a one-cycle reset
      pre = int'($urandom_range(12, 200));
      repeat (pre) step();
      chk("busy_mid_dc", 32'(busy), 1);
      chk("mode_mid_dc", 32'(led_mode), 1);
      do_reset(1);
      expect_shift(1'b1, DC_LEN, 1'b0, -1);
      expect_latch(1'b0, 1'b0);
      expect_shift(1'b0, GS_LEN + 1, 1'b1, -1);
      expect_latch(1'b1, 1'b0);
      reshuffle();
      expect_shift(1'b0, GS_LEN, 1'b0, int'($urandom_range(5, 180)));
      expect_latch(1'b1, 1'b1);
      expect_shift(1'b1, DC_LEN, 1'b0, -1);
      expect_latch(1'b0, 1'b0);
      reshuffle();
      expect_shift(1'b0, GS_LEN + 1, 1'b1, -1);
      expect_latch(1'b1, 1'b0);
      repeat (20) step();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end
endmodule
